// File: rtl/intc_vector_ctrl_pkg.sv
// Shared definitions for the interrupt vector controller: register
// offsets, FSM state encodings, default vector LSBs and byte-lane helpers.
package intc_vector_ctrl_pkg;

    // Width of a source index; covers up to 16 maskable sources.
    localparam int IDX_W = 4;

    // Register offsets relative to the block base address.
    localparam logic [2:0] IE_OFS     = 3'd0;
    localparam logic [2:0] IFG_OFS    = 3'd2;
    localparam logic [2:0] IV_OFS     = 3'd4;
    localparam logic [2:0] NMICTL_OFS = 3'd6;

    // Default vector LSBs: source 0 -> 0xFFFA, NMI -> 0xFFFC.
    localparam logic [5:0] DEF_BASE_VEC = 6'h3D;
    localparam logic [5:0] DEF_NMI_VEC  = 6'h3E;

    // Request/acknowledge handshake states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // Byte-lane write mask: full word, or the lane picked by address bit 0.
    function automatic logic [15:0] lane_mask(input logic bw, input logic a0);
        logic [15:0] m;
        if (!bw) begin
            m = 16'hFFFF;
        end else if (a0) begin
            m = 16'hFF00;
        end else begin
            m = 16'h00FF;
        end
        return m;
    endfunction

    // Align write data to its lane; byte writes always take the low data byte.
    function automatic logic [15:0] lane_data(input logic bw, input logic a0,
                                              input logic [15:0] d);
        logic [15:0] r;
        if (!bw) begin
            r = d;
        end else if (a0) begin
            r = {d[7:0], 8'h00};
        end else begin
            r = {8'h00, d[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/intc_vector_ctrl_prio_enc.sv
// Lowest-index-first priority encoder. Index 0 has the highest priority.
// Shared by the IV register readback and the vector address output.
import intc_vector_ctrl_pkg::*;

module intc_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0]     i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest set index is the last one kept.
    always_comb begin
        o_idx   = {IDX_W{1'b0}};
        o_valid = |i_req;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = i[IDX_W-1:0];
            end else begin
                o_idx = o_idx;
            end
        end
    end

endmodule

// File: rtl/intc_vector_ctrl.sv
// Memory-mapped interrupt controller: latches source edges into IFG, masks
// with IE, arbitrates (NMI first, then lowest index) and drives INT/NMI plus
// the vector LSBs. The acknowledge clears the winning flag and holds the
// vector steady for the whole INTACK pulse.
// Build option: define INTC_NMI_EN to include the NMI input, NMIIFG flag and
// NMICTL register; without it NMI is tied low and NMICTL reads 0.
import intc_vector_ctrl_pkg::*;

module intc_vector_ctrl #(
    parameter int          N_SRC     = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0160,
    parameter logic [5:0]  BASE_VEC  = DEF_BASE_VEC,
    parameter logic [5:0]  NMI_VEC   = DEF_NMI_VEC
) (
    input  logic             MCLK,
    input  logic             reset,
    input  logic [15:0]      MAB,
    input  logic [15:0]      MDBout,
    input  logic             MW,
    input  logic             BW,
    output logic [15:0]      MDBin,
    input  logic [N_SRC-1:0] src_in,
    input  logic             nmi_in,
    input  logic             INTACK,
    output logic             INT,
    output logic             NMI,
    output logic [5:0]       IntAddrLSBs
);

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] r_ie;
    logic [N_SRC-1:0] r_ifg;
    logic [N_SRC-1:0] r_src_smp;
    logic [N_SRC-1:0] r_src_prev;
    logic [5:0]       r_hold_vec;
    state_t           r_state;
    state_t           w_state_nx;

    logic [15:0]      w_ofs_full;
    logic             w_hit;
    logic [2:0]       w_ofs;
    logic             w_wr_ie;
    logic             w_wr_ifg;
    logic             w_wr_nmictl;
    logic [15:0]      w_wmask;
    logic [15:0]      w_wdata;
    logic             w_unused_bits;

    logic [N_SRC-1:0] w_src_rise;
    logic [N_SRC-1:0] w_pend;
    logic             w_pend_vld;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_nmiifg;
    logic             w_ack_edge;
    logic             w_ack_clr_ifg;
    logic [N_SRC-1:0] w_ifg_clr_mask;
    logic [N_SRC-1:0] w_ifg_nx;
    logic [N_SRC-1:0] w_ie_nx;
    logic [15:0]      w_ie_ext;
    logic [15:0]      w_ifg_ext;
    logic [15:0]      w_iv;
    logic [5:0]       w_vec;
    logic [15:0]      w_rdata;

    // ------------------------------------------------------------------
    // Address decode (bit 0 of the address only selects a byte lane)
    // ------------------------------------------------------------------
    assign w_ofs_full  = {MAB[15:1], 1'b0} - BASE_ADDR;
    assign w_hit       = (w_ofs_full[15:3] == 13'd0);
    assign w_ofs       = w_ofs_full[2:0];
    assign w_wr_ie     = MW & w_hit & (w_ofs == IE_OFS);
    assign w_wr_ifg    = MW & w_hit & (w_ofs == IFG_OFS);
    assign w_wr_nmictl = MW & w_hit & (w_ofs == NMICTL_OFS);
    assign w_wmask     = lane_mask(BW, MAB[0]);
    assign w_wdata     = lane_data(BW, MAB[0], MDBout);
    // Lane bits above N_SRC are legitimately dropped for narrow builds.
    assign w_unused_bits = ^{w_wmask, w_wdata};

    // ------------------------------------------------------------------
    // Edge detection and arbitration
    // ------------------------------------------------------------------
    assign w_src_rise = r_src_smp & ~r_src_prev;
    assign w_pend     = r_ifg & r_ie;
    assign w_ack_edge = (r_state == ST_IDLE) & INTACK;

    intc_prio_enc #(
        .N (N_SRC)
    ) u_prio_enc (
        .i_req   (w_pend),
        .o_valid (w_pend_vld),
        .o_idx   (w_win_idx)
    );

    // An NMI always outranks maskable sources, so the IFG clear only fires
    // when no NMI flag is pending.
    assign w_ack_clr_ifg = w_ack_edge & ~w_nmiifg & w_pend_vld;

    // One-hot clear mask for the acknowledged maskable source.
    always_comb begin
        w_ifg_clr_mask = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            if (w_ack_clr_ifg && (w_win_idx == i[IDX_W-1:0])) begin
                w_ifg_clr_mask[i] = 1'b1;
            end else begin
                w_ifg_clr_mask[i] = 1'b0;
            end
        end
    end

    // IFG next value: software write, then ack clear, then hardware set wins.
    always_comb begin
        w_ifg_nx = r_ifg;
        if (w_wr_ifg) begin
            w_ifg_nx = (r_ifg & ~w_wmask[N_SRC-1:0]) |
                       (w_wdata[N_SRC-1:0] & w_wmask[N_SRC-1:0]);
        end else begin
            w_ifg_nx = r_ifg;
        end
        w_ifg_nx = (w_ifg_nx & ~w_ifg_clr_mask) | w_src_rise;
    end

    // IE next value with byte-lane merge.
    always_comb begin
        w_ie_nx = r_ie;
        if (w_wr_ie) begin
            w_ie_nx = (r_ie & ~w_wmask[N_SRC-1:0]) |
                      (w_wdata[N_SRC-1:0] & w_wmask[N_SRC-1:0]);
        end else begin
            w_ie_nx = r_ie;
        end
    end

    // Sample source levels every cycle for rising-edge detection.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            r_src_smp  <= {N_SRC{1'b0}};
            r_src_prev <= {N_SRC{1'b0}};
        end else begin
            r_src_smp  <= src_in;
            r_src_prev <= r_src_smp;
        end
    end

    // Enable and flag registers.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            r_ie  <= {N_SRC{1'b0}};
            r_ifg <= {N_SRC{1'b0}};
        end else begin
            r_ie  <= w_ie_nx;
            r_ifg <= w_ifg_nx;
        end
    end

    // ------------------------------------------------------------------
    // Optional NMI path
    // ------------------------------------------------------------------
`ifdef INTC_NMI_EN
    logic r_nmi_smp;
    logic r_nmi_prev;
    logic r_nmiifg;
    logic w_nmi_rise;
    logic w_nmictl_clr;
    logic w_nmiifg_nx;

    assign w_nmi_rise   = r_nmi_smp & ~r_nmi_prev;
    assign w_nmictl_clr = w_wr_nmictl & w_wmask[0] & ~w_wdata[0];
    assign w_nmiifg     = r_nmiifg;

    // NMIIFG next value: write-0-to-clear and ack clear lose to a new edge.
    always_comb begin
        w_nmiifg_nx = r_nmiifg;
        if (w_nmictl_clr || (w_ack_edge && r_nmiifg)) begin
            w_nmiifg_nx = 1'b0;
        end else begin
            w_nmiifg_nx = r_nmiifg;
        end
        w_nmiifg_nx = w_nmiifg_nx | w_nmi_rise;
    end

    // NMI level sampling and flag storage.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            r_nmi_smp  <= 1'b0;
            r_nmi_prev <= 1'b0;
            r_nmiifg   <= 1'b0;
        end else begin
            r_nmi_smp  <= nmi_in;
            r_nmi_prev <= r_nmi_smp;
            r_nmiifg   <= w_nmiifg_nx;
        end
    end
`else
    logic w_unused_nmi;

    assign w_nmiifg     = 1'b0;
    assign w_unused_nmi = nmi_in ^ w_wr_nmictl;
`endif

    // ------------------------------------------------------------------
    // Vector and IV computation
    // ------------------------------------------------------------------
    assign w_vec = w_nmiifg   ? NMI_VEC :
                   w_pend_vld ? (BASE_VEC - {2'b00, w_win_idx}) : 6'h00;
    assign w_iv  = w_pend_vld ? {10'd0, ({1'b0, w_win_idx} + 5'd1), 1'b0}
                              : 16'h0000;

    // Zero-extend the N_SRC-wide registers to the bus width.
    always_comb begin
        w_ie_ext  = 16'h0000;
        w_ifg_ext = 16'h0000;
        w_ie_ext[N_SRC-1:0]  = r_ie;
        w_ifg_ext[N_SRC-1:0] = r_ifg;
    end

    // Combinational register readback; 0 when the block is not addressed.
    always_comb begin
        w_rdata = 16'h0000;
        if (w_hit) begin
            case (w_ofs)
                IE_OFS:     w_rdata = w_ie_ext;
                IFG_OFS:    w_rdata = w_ifg_ext;
                IV_OFS:     w_rdata = w_iv;
                NMICTL_OFS: w_rdata = {15'd0, w_nmiifg};
                default:    w_rdata = 16'h0000;
            endcase
        end else begin
            w_rdata = 16'h0000;
        end
    end

    assign MDBin = w_rdata;

    // ------------------------------------------------------------------
    // Acknowledge FSM
    // ------------------------------------------------------------------
    // State register; reset forces IDLE even in the middle of an ack.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state: enter ACK on INTACK, leave once INTACK drops.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (INTACK) begin
                    w_state_nx = ST_ACK;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (INTACK) begin
                    w_state_nx = ST_ACK;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Capture the vector being acknowledged so it stays stable during ACK.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            r_hold_vec <= 6'h00;
        end else if (w_ack_edge) begin
            r_hold_vec <= w_vec;
        end else begin
            r_hold_vec <= r_hold_vec;
        end
    end

    // Outputs: live requests in IDLE, masked requests and held vector in ACK.
    always_comb begin
        INT         = 1'b0;
        NMI         = 1'b0;
        IntAddrLSBs = 6'h00;
        case (r_state)
            ST_IDLE: begin
                INT         = w_pend_vld;
                NMI         = w_nmiifg;
                IntAddrLSBs = w_vec;
            end
            ST_ACK: begin
                INT         = 1'b0;
                NMI         = 1'b0;
                IntAddrLSBs = r_hold_vec;
            end
            default: begin
                INT         = 1'b0;
                NMI         = 1'b0;
                IntAddrLSBs = 6'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_intc_vector_ctrl.sv
// Directed bench for intc_vector_ctrl (N_SRC=16). Expected values are pushed
// to a scoreboard queue as stimulus is applied and popped when the DUT
// output is sampled one time unit after the clock edge.
`timescale 1ns/1ps

module tb_intc_vector_ctrl;

    logic        MCLK;
    logic        reset;
    logic [15:0] MAB;
    logic [15:0] MDBout;
    logic        MW;
    logic        BW;
    logic [15:0] MDBin;
    logic [15:0] src_in;
    logic        nmi_in;
    logic        INTACK;
    logic        INT;
    logic        NMI;
    logic [5:0]  IntAddrLSBs;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    intc_vector_ctrl #(
        .N_SRC     (16),
        .BASE_ADDR (16'h0160),
        .BASE_VEC  (6'h3D),
        .NMI_VEC   (6'h3E)
    ) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .MAB         (MAB),
        .MDBout      (MDBout),
        .MW          (MW),
        .BW          (BW),
        .MDBin       (MDBin),
        .src_in      (src_in),
        .nmi_in      (nmi_in),
        .INTACK      (INTACK),
        .INT         (INT),
        .NMI         (NMI),
        .IntAddrLSBs (IntAddrLSBs)
    );

    initial MCLK = 1'b0;
    always #50 MCLK = ~MCLK;

    task automatic expect_v(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic got(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] v);
        expect_v(tag, v);
        got(obs);
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input string tag, input logic [15:0] v);
        expect_v(tag, v);
        MAB = a;
        #1;
        got(MDBin);
        MAB = 16'h0000;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic bw);
        MAB    = a;
        MDBout = d;
        BW     = bw;
        MW     = 1'b1;
        tick();
        MW     = 1'b0;
        BW     = 1'b0;
        MAB    = 16'h0000;
        MDBout = 16'h0000;
    endtask

    initial begin
        reset  = 1'b1;
        MAB    = 16'h0000;
        MDBout = 16'h0000;
        MW     = 1'b0;
        BW     = 1'b0;
        src_in = 16'h0000;
        nmi_in = 1'b0;
        INTACK = 1'b0;
        #10;
        chk("rst_int", {15'd0, INT}, 16'h0000);
        chk("rst_nmi", {15'd0, NMI}, 16'h0000);
        chk("rst_vec", {10'd0, IntAddrLSBs}, 16'h0000);
        chk("rst_mdbin", MDBin, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Post-reset register contents
        rd(16'h0160, "ie_rst", 16'h0000);
        rd(16'h0162, "ifg_rst", 16'h0000);
        rd(16'h0164, "iv_rst", 16'h0000);
        chk("idle_int", {15'd0, INT}, 16'h0000);

        // Enable sources 2 and 4, pulse both on the same cycle
        wr(16'h0160, 16'h0014, 1'b0);
        rd(16'h0160, "ie_wr", 16'h0014);
        src_in = 16'h0014;
        expect_v("int_after_sample", 16'h0000);
        tick();
        src_in = 16'h0000;
        got({15'd0, INT});
        expect_v("int_after_capture", 16'h0001);
        expect_v("vec_src2", 16'h003B);
        tick();
        got({15'd0, INT});
        got({10'd0, IntAddrLSBs});
        rd(16'h0164, "iv_src2", 16'h0006);
        rd(16'h0162, "ifg_2_4", 16'h0014);

        // Three-cycle acknowledge of source 2
        INTACK = 1'b1;
        tick();
        chk("ack_int", {15'd0, INT}, 16'h0000);
        chk("ack_vec1", {10'd0, IntAddrLSBs}, 16'h003B);
        rd(16'h0162, "ifg_after_ack", 16'h0010);
        tick();
        chk("ack_vec2", {10'd0, IntAddrLSBs}, 16'h003B);
        tick();
        chk("ack_vec3", {10'd0, IntAddrLSBs}, 16'h003B);
        chk("ack_int3", {15'd0, INT}, 16'h0000);
        INTACK = 1'b0;
        tick();
        chk("post_ack_int", {15'd0, INT}, 16'h0001);
        chk("post_ack_vec", {10'd0, IntAddrLSBs}, 16'h0039);
        rd(16'h0164, "iv_src4", 16'h000A);

        // Acknowledge source 4, nothing left pending
        INTACK = 1'b1;
        tick();
        INTACK = 1'b0;
        tick();
        rd(16'h0162, "ifg_empty", 16'h0000);
        chk("empty_int", {15'd0, INT}, 16'h0000);
        chk("empty_vec", {10'd0, IntAddrLSBs}, 16'h0000);

        // Byte-lane writes to IE
        wr(16'h0160, 16'h0000, 1'b0);
        wr(16'h0161, 16'h00FF, 1'b1);
        rd(16'h0160, "ie_hi_byte", 16'hFF00);
        wr(16'h0160, 16'hAB12, 1'b1);
        rd(16'h0160, "ie_lo_byte", 16'hFF12);

        // Priority extremes: source 0 and source 15
        wr(16'h0160, 16'h8001, 1'b0);
        wr(16'h0162, 16'h8001, 1'b0);
        chk("sw_set_int", {15'd0, INT}, 16'h0001);
        chk("vec_src0", {10'd0, IntAddrLSBs}, 16'h003D);
        rd(16'h0164, "iv_src0", 16'h0002);
        wr(16'h0162, 16'h8000, 1'b0);
        chk("vec_src15", {10'd0, IntAddrLSBs}, 16'h002E);
        rd(16'h0164, "iv_src15", 16'h0020);
        wr(16'h0162, 16'h0000, 1'b0);
        wr(16'h0160, 16'h0002, 1'b0);

        // Software clear of IFG[1] on the capture edge: hardware set wins
        wr(16'h0162, 16'h0002, 1'b0);
        chk("sw_set_vec", {10'd0, IntAddrLSBs}, 16'h003C);
        src_in = 16'h0002;
        tick();
        src_in = 16'h0000;
        wr(16'h0162, 16'h0000, 1'b0);
        rd(16'h0162, "hw_beats_sw_clr", 16'h0002);
        wr(16'h0162, 16'h0000, 1'b0);
        rd(16'h0162, "sw_clr_alone", 16'h0000);
        src_in = 16'h0002;
        tick();
        src_in = 16'h0000;
        wr(16'h0162, 16'h0000, 1'b0);
        rd(16'h0162, "hw_set_on_clr_edge", 16'h0002);

        // Acknowledge clear on the same edge as a new event keeps the flag
        src_in = 16'h0002;
        tick();
        src_in = 16'h0000;
        INTACK = 1'b1;
        tick();
        chk("ack_hw_vec", {10'd0, IntAddrLSBs}, 16'h003C);
        INTACK = 1'b0;
        tick();
        rd(16'h0162, "ack_vs_hw_set", 16'h0002);
        chk("ack_vs_hw_int", {15'd0, INT}, 16'h0001);
        wr(16'h0162, 16'h0000, 1'b0);

        // Reset in the middle of ACK
        wr(16'h0160, 16'h0004, 1'b0);
        wr(16'h0162, 16'h0004, 1'b0);
        INTACK = 1'b1;
        tick();
        chk("pre_rst_vec", {10'd0, IntAddrLSBs}, 16'h003B);
        #10;
        reset = 1'b1;
        #1;
        chk("mid_ack_rst_vec", {10'd0, IntAddrLSBs}, 16'h0000);
        chk("mid_ack_rst_int", {15'd0, INT}, 16'h0000);
        rd(16'h0160, "mid_ack_rst_ie", 16'h0000);
        INTACK = 1'b0;
        #1;
        reset = 1'b0;
        tick();
        INTACK = 1'b1;
        tick();
        chk("empty_ack_vec", {10'd0, IntAddrLSBs}, 16'h0000);
        chk("empty_ack_int", {15'd0, INT}, 16'h0000);
        INTACK = 1'b0;
        tick();
        rd(16'h0162, "empty_ack_ifg", 16'h0000);
        rd(16'h0160, "empty_ack_ie", 16'h0000);

`ifdef INTC_NMI_EN
        // NMI outranks maskable source 0; ack clears NMIIFG only
        wr(16'h0160, 16'h0001, 1'b0);
        wr(16'h0162, 16'h0001, 1'b0);
        nmi_in = 1'b1;
        tick();
        tick();
        chk("nmi_out", {15'd0, NMI}, 16'h0001);
        chk("nmi_vec", {10'd0, IntAddrLSBs}, 16'h003E);
        rd(16'h0166, "nmictl_set", 16'h0001);
        INTACK = 1'b1;
        tick();
        chk("nmi_ack_vec", {10'd0, IntAddrLSBs}, 16'h003E);
        chk("nmi_ack_nmi", {15'd0, NMI}, 16'h0000);
        rd(16'h0166, "nmictl_acked", 16'h0000);
        rd(16'h0162, "ifg0_kept", 16'h0001);
        INTACK = 1'b0;
        tick();
        chk("nmi_rel_vec", {10'd0, IntAddrLSBs}, 16'h003D);
        chk("nmi_rel_int", {15'd0, INT}, 16'h0001);
        // Write-0-to-clear behaviour of NMICTL
        nmi_in = 1'b0;
        tick();
        nmi_in = 1'b1;
        tick();
        tick();
        wr(16'h0166, 16'h0001, 1'b0);
        rd(16'h0166, "nmictl_w1_keep", 16'h0001);
        wr(16'h0166, 16'hFFFE, 1'b0);
        rd(16'h0166, "nmictl_w0_clr", 16'h0000);
        chk("nmi_cleared", {15'd0, NMI}, 16'h0000);
        nmi_in = 1'b0;
`else
        // Without the NMI build option the path is absent
        nmi_in = 1'b1;
        tick();
        tick();
        chk("nmi_tied", {15'd0, NMI}, 16'h0000);
        wr(16'h0166, 16'h0001, 1'b0);
        rd(16'h0166, "nmictl_zero", 16'h0000);
        chk("nmi_vec_none", {10'd0, IntAddrLSBs}, 16'h0000);
        nmi_in = 1'b0;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
